// File: rtl/hanoi_pkg.sv
// Shared types for the Tower of Hanoi move generator.
// Pole codes, generator FSM states and peg-to-pole mapping.
package hanoi_pkg;

  typedef logic [1:0] pole_t;

  localparam pole_t POLE_LEFT  = 2'b00;
  localparam pole_t POLE_MID   = 2'b01;
  localparam pole_t POLE_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } gen_state_t;

  // Swap pegs 1/2 for an even disk count so the tower ends on right.
  function automatic pole_t peg_to_pole(
    input logic [1:0] peg,
    input logic       s_odd
  );
    pole_t p;
    case (peg)
      2'd0:    p = POLE_LEFT;
      2'd1:    p = s_odd ? POLE_MID : POLE_RIGHT;
      2'd2:    p = s_odd ? POLE_RIGHT : POLE_MID;
      default: p = POLE_LEFT;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/hanoi_mod3.sv
// Combinational x mod 3 for an arbitrary width.
// Bit i contributes 1 (even i) or 2 (odd i) modulo 3.
module hanoi_mod3 #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  output logic [1:0]   r
);

  function automatic logic [1:0] add_mod3(
    input logic [1:0] a,
    input logic [1:0] b
  );
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Fold the weighted bits into a running residue.
  always_comb begin
    r = 2'd0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) r = add_mod3(r, (i % 2 == 1) ? 2'd2 : 2'd1);
    end
  end

endmodule

// File: rtl/hanoi_move_gen.sv
// Optimal Tower of Hanoi move generator with valid/ready output.
// Optional shadow pole checker: define HANOI_SHADOW_CHECK_EN.
module hanoi_move_gen
  import hanoi_pkg::*;
#(
  parameter int S = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         move_ready,
  output logic         move_valid,
  output logic [1:0]   fr,
  output logic [1:0]   to,
  output logic [S-1:0] move_idx,
  output logic         busy,
  output logic         done,
  output logic         illegal
);

  localparam logic [S-1:0] LAST  = '1;
  localparam logic [S-1:0] ONE   = S'(1);
  localparam logic [S:0]   ONE_W = (S+1)'(1);
  localparam logic         S_ODD = (S % 2) == 1;

  gen_state_t     state, state_n;
  logic           valid_n, busy_n, done_n;
  logic [1:0]     fr_n, to_n;
  logic [S-1:0]   idx_n;
  logic [S-1:0]   nxt, and_t;
  logic [S:0]     or_t;
  logic [1:0]     src_peg, dst_peg;
  logic           xfer;

  assign xfer = move_valid & move_ready;

  // Index of the move to load next: 1 on start, else m+1.
  always_comb begin
    nxt   = (state == RUN) ? move_idx + ONE : ONE;
    and_t = nxt & (nxt - ONE);
    or_t  = {1'b0, nxt | (nxt - ONE)} + ONE_W;
  end

  hanoi_mod3 #(.W(S)) u_src (
    .x (and_t),
    .r (src_peg)
  );

  hanoi_mod3 #(.W(S+1)) u_dst (
    .x (or_t),
    .r (dst_peg)
  );

  // Next-state and next-output logic of the generator FSM.
  always_comb begin
    state_n = state;
    valid_n = move_valid;
    fr_n    = fr;
    to_n    = to;
    idx_n   = move_idx;
    done_n  = done;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          valid_n = 1'b1;
          idx_n   = ONE;
          fr_n    = peg_to_pole(src_peg, S_ODD);
          to_n    = peg_to_pole(dst_peg, S_ODD);
          done_n  = 1'b0;
        end
      end
      RUN: begin
        if (xfer) begin
          if (move_idx == LAST) begin
            state_n = DONE;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n = nxt;
            fr_n  = peg_to_pole(src_peg, S_ODD);
            to_n  = peg_to_pole(dst_peg, S_ODD);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      move_valid <= 1'b0;
      fr         <= POLE_LEFT;
      to         <= POLE_LEFT;
      move_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      move_valid <= valid_n;
      fr         <= fr_n;
      to         <= to_n;
      move_idx   <= idx_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

`ifdef HANOI_SHADOW_CHECK_EN
  // Shadow poles: MSB is the smallest disk.
  logic [S-1:0] sh_l, sh_m, sh_r;
  logic [S-1:0] l_n, m_n, r_n;
  logic [S-1:0] src_v, dst_v, mask;
  logic         bad, fin_bad;

  // Apply the pending move to the shadow poles and judge it.
  always_comb begin
    case (fr)
      POLE_LEFT: src_v = sh_l;
      POLE_MID:  src_v = sh_m;
      default:   src_v = sh_r;
    endcase
    case (to)
      POLE_LEFT: dst_v = sh_l;
      POLE_MID:  dst_v = sh_m;
      default:   dst_v = sh_r;
    endcase
    mask = '0;
    for (int i = 0; i < S; i++) begin
      if (src_v[i]) begin
        mask    = '0;
        mask[i] = 1'b1;
      end
    end
    l_n = sh_l;
    m_n = sh_m;
    r_n = sh_r;
    case (fr)
      POLE_LEFT: l_n = l_n & ~mask;
      POLE_MID:  m_n = m_n & ~mask;
      default:   r_n = r_n & ~mask;
    endcase
    case (to)
      POLE_LEFT: l_n = l_n | mask;
      POLE_MID:  m_n = m_n | mask;
      default:   r_n = r_n | mask;
    endcase
    bad     = (src_v == '0) || (src_v <= dst_v);
    fin_bad = (move_idx == LAST) && (r_n != '1);
  end

  // Shadow registers and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst || (start && state != RUN)) begin
      sh_l    <= '1;
      sh_m    <= '0;
      sh_r    <= '0;
      illegal <= 1'b0;
    end else if (xfer) begin
      sh_l    <= l_n;
      sh_m    <= m_n;
      sh_r    <= r_n;
      illegal <= illegal | bad | fin_bad;
    end
  end

  // The generated sequence must never break the puzzle rules.
  always_ff @(posedge clk) begin
    if (!rst) assert (!illegal);
  end
`else
  assign illegal = 1'b0;
`endif

endmodule
